regfile_read_ctrl: RTL and testbench

//  Read-side controller for a register file built from 9-bit bitline registers.
//  - Accepts dual-address read requests over a valid/ready handshake.
//  - Drives one-hot ReadEnable1/ReadEnable2 wordlines and samples the shared Bitline1/Bitline2 buses.
//  - Returns both operands over a valid/ready response channel.
//  - Sits between decode and the register array; the register array's write port is observed for optional forwarding.

---
 rtl/regfile_read_ctrl.sv | 106 ++++++++++
 tb/tb_regfile_read_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_read_ctrl.sv
// rtl/regfile_read_ctrl.sv - dual-port read controller driving one-hot wordlines and capturing bitlines
// Optional write-forwarding into the captured operands: define REGREAD_BYPASS_EN.
module regfile_read_ctrl #(
  parameter int NUM_REGS = 16,
  parameter int WIDTH    = 9,
  parameter int ADDR_W   = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [ADDR_W-1:0]   rd_addr1,
  input  logic [ADDR_W-1:0]   rd_addr2,
  output logic [NUM_REGS-1:0] ReadEnable1,
  output logic [NUM_REGS-1:0] ReadEnable2,
  input  logic [WIDTH-1:0]    Bitline1,
  input  logic [WIDTH-1:0]    Bitline2,
  input  logic                wr_en,
  input  logic [ADDR_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]    wr_data,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WIDTH-1:0]    rsp_data1,
  output logic [WIDTH-1:0]    rsp_data2
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr1_q, addr1_d, addr2_q, addr2_d;
  logic [WIDTH-1:0]  data1_q, data1_d, data2_q, data2_d;
  logic              in_range1, in_range2;
  logic              byp1, byp2;

  assign in_range1 = (int'(addr1_q) < NUM_REGS);
  assign in_range2 = (int'(addr2_q) < NUM_REGS);

`ifdef REGREAD_BYPASS_EN
  assign byp1 = wr_en && in_range1 && (wr_addr == addr1_q);
  assign byp2 = wr_en && in_range2 && (wr_addr == addr2_q);
`else
  logic unused_wr;
  assign unused_wr = ^{wr_en, wr_addr, wr_data};
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      addr1_q <= '0;
      addr2_q <= '0;
      data1_q <= '0;
      data2_q <= '0;
    end else begin
      state_q <= state_d;
      addr1_q <= addr1_d;
      addr2_q <= addr2_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr1_d = addr1_q;
    addr2_d = addr2_q;
    data1_d = data1_q;
    data2_d = data2_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr1_d = rd_addr1;
          addr2_d = rd_addr2;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        // Out-of-range ports return zero regardless of what the bus carries.
        data1_d = !in_range1 ? '0 : (byp1 ? wr_data : Bitline1);
        data2_d = !in_range2 ? '0 : (byp2 ? wr_data : Bitline2);
        state_d = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Wordlines decode only from registered state, so they can never glitch to multi-hot.
  always_comb begin
    ReadEnable1 = '0;
    ReadEnable2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ReadEnable1[i] = (state_q == DRIVE) && (addr1_q == ADDR_W'(i));
      ReadEnable2[i] = (state_q == DRIVE) && (addr2_q == ADDR_W'(i));
    end
  end

  assign req_ready = rst && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_data1 = data1_q;
  assign rsp_data2 = data2_q;

endmodule

// File: tb/tb_regfile_read_ctrl.sv
// tb/tb_regfile_read_ctrl.sv - directed self-checking bench for regfile_read_ctrl with a behavioural array
module tb_regfile_read_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, req_valid, rsp_ready, wr_en;
  logic [3:0]  rd_addr1, rd_addr2, wr_addr;
  logic [4:0]  rd_addr1_5;
  logic [8:0]  wr_data;

  logic        req_ready, rsp_valid;
  logic [15:0] re1, re2;
  logic [8:0]  bl1, bl2, d1, d2;

  logic        req_ready_5, rsp_valid_5;
  logic [15:0] re1_5, re2_5;
  logic [8:0]  bl1_5, bl2_5, d1_5, d2_5;

  logic [8:0]  mem [16];

`ifdef REGREAD_BYPASS_EN
  localparam logic [8:0] EXP_FWD = 9'h055;
`else
  localparam logic [8:0] EXP_FWD = 9'h1A5;
`endif

  regfile_read_ctrl dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
    .ReadEnable1(re1), .ReadEnable2(re2), .Bitline1(bl1), .Bitline2(bl2),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data1(d1), .rsp_data2(d2)
  );

  regfile_read_ctrl #(.NUM_REGS(16), .WIDTH(9), .ADDR_W(5)) dut5 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_5),
    .rd_addr1(rd_addr1_5), .rd_addr2({1'b0, rd_addr2}),
    .ReadEnable1(re1_5), .ReadEnable2(re2_5), .Bitline1(bl1_5), .Bitline2(bl2_5),
    .wr_en(wr_en), .wr_addr({1'b0, wr_addr}), .wr_data(wr_data),
    .rsp_valid(rsp_valid_5), .rsp_ready(rsp_ready), .rsp_data1(d1_5), .rsp_data2(d2_5)
  );

  always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;

  // Bitlines are a wired-OR of every enabled row.
  always_comb begin
    bl1 = '0; bl2 = '0; bl1_5 = '0; bl2_5 = '0;
    for (int i = 0; i < 16; i++) begin
      if (re1[i])   bl1   = bl1   | mem[i];
      if (re2[i])   bl2   = bl2   | mem[i];
      if (re1_5[i]) bl1_5 = bl1_5 | mem[i];
      if (re2_5[i]) bl2_5 = bl2_5 | mem[i];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  always @(negedge clk)
    check_eq("wordline_onehot",
             32'(($countones(re1) <= 1) && ($countones(re2) <= 1) && ($countones(re1_5) <= 1)), 32'd1);

  task automatic write_reg(input logic [3:0] a, input logic [8:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic issue(input logic [3:0] a1, input logic [3:0] a2, input logic [4:0] a1_5);
    req_valid = 1'b1; rd_addr1 = a1; rd_addr2 = a2; rd_addr1_5 = a1_5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic collect();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic accept_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0; wr_en = 1'b0;
    rd_addr1 = '0; rd_addr2 = '0; rd_addr1_5 = '0; wr_addr = '0; wr_data = '0;
    #12;
    check_eq("rst_req_ready", req_ready, 0);
    check_eq("rst_enables", {re1, re2}, 0);
    check_eq("rst_rsp_valid", rsp_valid, 0);
    check_eq("rst_data", {d1, d2}, 0);

    write_reg(4'd3, 9'h1A5);
    write_reg(4'd7, 9'h0F0);
    write_reg(4'd5, 9'h1FF);
    @(negedge clk); rst = 1'b1; #1;
    check_eq("rel_req_ready", req_ready, 1);
    @(posedge clk); #1;

    // Basic two-port read
    issue(4'd3, 4'd7, 5'd3);
    check_eq("t1_re1", re1, 16'h0008);
    check_eq("t1_re2", re2, 16'h0080);
    check_eq("t1_rsp_valid_drive", rsp_valid, 0);
    check_eq("t1_req_ready_drive", req_ready, 0);
    collect();
    check_eq("t1_enables_resp", {re1, re2}, 0);
    check_eq("t1_rsp_valid", rsp_valid, 1);
    check_eq("t1_d1", d1, 9'h1A5);
    check_eq("t1_d2", d2, 9'h0F0);

    // Backpressure: response held stable
    for (int k = 0; k < 5; k++) begin
      check_eq("t2_rsp_valid", rsp_valid, 1);
      check_eq("t2_data", {d1, d2}, {9'h1A5, 9'h0F0});
      check_eq("t2_req_ready", req_ready, 0);
      check_eq("t2_enables", {re1, re2}, 0);
      @(negedge clk);
    end
    accept_rsp();
    check_eq("t2_idle_valid", rsp_valid, 0);
    check_eq("t2_idle_ready", req_ready, 1);

    // Same address on both ports
    issue(4'd5, 4'd5, 5'd5);
    check_eq("t3_re1", re1, 16'h0020);
    check_eq("t3_re2", re2, 16'h0020);
    collect();
    check_eq("t3_d1", d1, 9'h1FF);
    check_eq("t3_d2", d2, 9'h1FF);
    accept_rsp();

    // Same-cycle write to port-1 address
    issue(4'd3, 4'd7, 5'd3);
    wr_en = 1'b1; wr_addr = 4'd3; wr_data = 9'h055;
    @(posedge clk); #1;
    wr_en = 1'b0;
    @(negedge clk);
    check_eq("t4_d1", d1, 32'(EXP_FWD));
    check_eq("t4_d2", d2, 9'h0F0);
    check_eq("t4_d1_w5", d1_5, 32'(EXP_FWD));
    accept_rsp();

    // Out-of-range port-1 on the ADDR_W=5 instance
    issue(4'd3, 4'd7, 5'd20);
    check_eq("t5_re1", re1_5, 16'h0000);
    check_eq("t5_re2", re2_5, 16'h0080);
    collect();
    check_eq("t5_re1_resp", re1_5, 16'h0000);
    check_eq("t5_d1", d1_5, 9'h000);
    check_eq("t5_d2", d2_5, 9'h0F0);
    check_eq("t5_main_d1", d1, 9'h055);
    accept_rsp();

    // Reset during DRIVE
    issue(4'd5, 4'd7, 5'd5);
    check_eq("t6_re1_pre", re1, 16'h0020);
    rst = 1'b0; #1;
    check_eq("t6_enables", {re1, re2}, 0);
    check_eq("t6_rsp_valid", rsp_valid, 0);
    check_eq("t6_req_ready", req_ready, 0);
    @(posedge clk); @(negedge clk);
    check_eq("t6_rsp_valid_hold", rsp_valid, 0);
    rst = 1'b1; #1;
    check_eq("t6_rel_ready", req_ready, 1);
    check_eq("t6_rel_valid", rsp_valid, 0);
    @(posedge clk); #1;
    issue(4'd7, 4'd5, 5'd7);
    check_eq("t6_re1", re1, 16'h0080);
    check_eq("t6_re2", re2, 16'h0020);
    collect();
    check_eq("t6_valid", rsp_valid, 1);
    check_eq("t6_d1", d1, 9'h0F0);
    check_eq("t6_d2", d2, 9'h1FF);
    accept_rsp();
    check_eq("t6_done", rsp_valid, 0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
